// File: rtl/bcd_time_counter.sv
// Time-of-day counter for the VGA clock display: prescales the pixel clock to
// a 1 Hz tick, keeps hh:mm:ss (hours binary, min/sec BCD), takes three
// debounced adjust buttons and renders hours in 12h or 24h form.
module bcd_time_counter #(
  parameter int TICKS_PER_SEC   = 31_500_000,
  parameter int DEBOUNCE_CYCLES = 65_536
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       adj_hrs,
  input  logic       adj_min,
  input  logic       adj_sec,
  input  logic       mode_12h,
  output logic [3:0] hrs_d,
  output logic [3:0] hrs_u,
  output logic [3:0] min_d,
  output logic [3:0] min_u,
  output logic [3:0] sec_d,
  output logic [3:0] sec_u,
  output logic       pm,
  output logic       sec_tick,
  output logic       day_tick
);

  localparam int PW = $clog2(TICKS_PER_SEC);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [PW-1:0] PS_LAST = PW'(TICKS_PER_SEC - 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  // Field indices shared by the button vectors: 0 = sec, 1 = min, 2 = hrs.
  logic [2:0]         btn_raw;
  logic [2:0]         sync_p0, sync_p1;
  logic [2:0]         acc_lvl;
  logic [2:0][DW-1:0] db_cnt;
  logic [2:0]         press_p2, press_p3;
  logic [2:0]         pend;
  logic [2:0]         inc;

  logic [PW-1:0] ps_cnt;
  logic          tick;
  logic [7:0]    sec_bcd, min_bcd;
  logic [4:0]    hour;
  logic          sec_last, min_last, hr_last;

  // BCD pair increment that wraps 59 -> 00.
  function automatic logic [7:0] bcd_inc59(input logic [7:0] v);
    if (v == 8'h59)
      return 8'h00;
    else if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    else
      return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Hour increment that wraps 23 -> 0.
  function automatic logic [4:0] hr_inc(input logic [4:0] h);
    return (h == 5'd23) ? 5'd0 : h + 5'd1;
  endfunction

  // Internal 0..23 hour to the two BCD display digits for the selected mode.
  function automatic logic [7:0] hour_disp(input logic [4:0] h, input logic m12);
    logic [4:0] v;
    v = h;
    if (m12) begin
      if (h == 5'd0)
        v = 5'd12;
      else if (h > 5'd12)
        v = h - 5'd12;
    end
    if (v >= 5'd20)
      return {4'd2, 4'(v - 5'd20)};
    else if (v >= 5'd10)
      return {4'd1, 4'(v - 5'd10)};
    else
      return {4'd0, v[3:0]};
  endfunction

  assign btn_raw  = {adj_hrs, adj_min, adj_sec};
  assign tick     = (ps_cnt == PS_LAST);
  assign sec_last = (sec_bcd == 8'h59);
  assign min_last = (min_bcd == 8'h59);
  assign hr_last  = (hour == 5'd23);
  // A press (fresh or deferred) lands only in a cycle the tick leaves free.
  assign inc      = (press_p3 | pend) & {3{~tick}};

  // Prescaler: free-running 0..TICKS_PER_SEC-1, untouched by adjusts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      ps_cnt <= '0;
    else if (tick)
      ps_cnt <= '0;
    else
      ps_cnt <= ps_cnt + PW'(1);
  end

  // Button path: synchronise, debounce against the accepted level, emit one
  // pulse per accepted rising level, then one more register stage so the
  // field sees it DEBOUNCE_CYCLES+3 edges after the raw level is first sampled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_p0  <= '0;
      sync_p1  <= '0;
      acc_lvl  <= '0;
      db_cnt   <= '0;
      press_p2 <= '0;
      press_p3 <= '0;
    end else begin
      sync_p0  <= btn_raw;
      sync_p1  <= sync_p0;
      press_p3 <= press_p2;
      for (int i = 0; i < 3; i++) begin
        press_p2[i] <= 1'b0;
        if (sync_p1[i] != acc_lvl[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            acc_lvl[i]  <= sync_p1[i];
            db_cnt[i]   <= '0;
            press_p2[i] <= sync_p1[i];
          end else begin
            db_cnt[i] <= db_cnt[i] + DW'(1);
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  // Time state: the tick wins with full carry; presses that collide with it
  // are parked in pend and applied (without carry) on the following cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sec_bcd  <= '0;
      min_bcd  <= '0;
      hour     <= '0;
      pend     <= '0;
      sec_tick <= 1'b0;
      day_tick <= 1'b0;
    end else begin
      sec_tick <= tick;
      day_tick <= tick & sec_last & min_last & hr_last;
      pend     <= tick ? (press_p3 | pend) : 3'b000;
      if (tick) begin
        sec_bcd <= bcd_inc59(sec_bcd);
        if (sec_last) begin
          min_bcd <= bcd_inc59(min_bcd);
          if (min_last)
            hour <= hr_inc(hour);
        end
      end else begin
        if (inc[0]) sec_bcd <= bcd_inc59(sec_bcd);
        if (inc[1]) min_bcd <= bcd_inc59(min_bcd);
        if (inc[2]) hour    <= hr_inc(hour);
      end
    end
  end

  // Hours display register, one cycle behind the internal hour.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      {hrs_d, hrs_u} <= 8'h00;
    else
      {hrs_d, hrs_u} <= hour_disp(hour, mode_12h);
  end

  assign {min_d, min_u} = min_bcd;
  assign {sec_d, sec_u} = sec_bcd;
  assign pm             = (hour >= 5'd12);

endmodule

// File: tb/tb_bcd_time_counter.sv
// Randomised and directed bench for bcd_time_counter, checked every cycle
// against a seconds-of-day reference model.
module tb_bcd_time_counter;

  localparam int TPS = 4;
  localparam int DB  = 3;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       adj_hrs, adj_min, adj_sec, mode_12h;
  logic [3:0] hrs_d, hrs_u, min_d, min_u, sec_d, sec_u;
  logic       pm, sec_tick, day_tick;
  logic [2:0] raw;

  assign adj_sec = raw[0];
  assign adj_min = raw[1];
  assign adj_hrs = raw[2];

  bcd_time_counter #(.TICKS_PER_SEC(TPS), .DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .reset_n(reset_n),
    .adj_hrs(adj_hrs), .adj_min(adj_min), .adj_sec(adj_sec), .mode_12h(mode_12h),
    .hrs_d(hrs_d), .hrs_u(hrs_u), .min_d(min_d), .min_u(min_u),
    .sec_d(sec_d), .sec_u(sec_u), .pm(pm), .sec_tick(sec_tick), .day_tick(day_tick)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: time of day as a plain second count.
  int          n;        // edges since reset release
  int          tod;      // 0..86399
  bit          r1[3], r2[3];
  bit          acc[3];
  int          run[3];
  int          due[3];
  bit          pend[3];
  logic [31:0] exp_vec;
  int          cyc = 0;
  int          last_st;
  int          day_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int m_hour();
    return tod / 3600;
  endfunction
  function automatic int m_min();
    return (tod / 60) % 60;
  endfunction
  function automatic int m_sec();
    return tod % 60;
  endfunction

  function automatic int bump(input int t, input int f);
    int h, m, s;
    h = t / 3600; m = (t / 60) % 60; s = t % 60;
    case (f)
      0: s = (s + 1) % 60;
      1: m = (m + 1) % 60;
      default: h = (h + 1) % 24;
    endcase
    return h * 3600 + m * 60 + s;
  endfunction

  function automatic int disp(input int h, input bit m12);
    return m12 ? ((h + 11) % 12 + 1) : h;
  endfunction

  function automatic logic [31:0] outs();
    return {5'd0, hrs_d, hrs_u, min_d, min_u, sec_d, sec_u, pm, sec_tick, day_tick};
  endfunction

  task automatic model_reset();
    n = 0; tod = 0; last_st = -1; exp_vec = '0;
    for (int b = 0; b < 3; b++) begin
      r1[b] = 0; r2[b] = 0; acc[b] = 0; run[b] = 0; due[b] = -1; pend[b] = 0;
    end
  endtask

  task automatic model_step();
    int ph, dh, h, m, s;
    bit tk, dy, now[3], smp;
    n++;
    tk = (n % TPS == 0);
    dy = 0;
    ph = m_hour();
    for (int b = 0; b < 3; b++) now[b] = (due[b] == n);
    if (tk) begin
      dy  = (tod == 86399);
      tod = (tod + 1) % 86400;
      for (int b = 0; b < 3; b++) if (now[b]) pend[b] = 1;
    end else begin
      for (int b = 0; b < 3; b++) begin
        if (now[b] || pend[b]) tod = bump(tod, b);
        pend[b] = 0;
      end
    end
    // A level is accepted once DB consecutive synchronised samples disagree
    // with the accepted one; a rising acceptance reaches the field 2 edges on.
    for (int b = 0; b < 3; b++) begin
      smp = r2[b]; r2[b] = r1[b]; r1[b] = raw[b];
      if (smp != acc[b]) run[b]++; else run[b] = 0;
      if (run[b] == DB) begin
        acc[b] = smp; run[b] = 0;
        if (smp) due[b] = n + 2;
      end
    end
    h = m_hour(); m = m_min(); s = m_sec(); dh = disp(ph, mode_12h);
    exp_vec = {5'd0, 4'(dh / 10), 4'(dh % 10), 4'(m / 10), 4'(m % 10),
               4'(s / 10), 4'(s % 10), (h >= 12), tk, dy};
  endtask

  task automatic cycle();
    @(posedge clk); #1;
    cyc++;
    if (!reset_n) model_reset();
    else model_step();
    check_eq("outs", outs(), exp_vec);
    if (sec_tick) begin
      if (last_st >= 0) check_eq("tick_gap", 32'(cyc - last_st), TPS);
      last_st = cyc;
    end
    if (day_tick) day_cnt++;
  endtask

  task automatic press(input int f);
    raw[f] = 1'b1;
    repeat (DB + 4) cycle();
    raw[f] = 1'b0;
    repeat (DB + 5) cycle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d expected end", cyc);
    $fatal(1);
  end

  initial begin
    int cnt, target, hcap;
    bit flag;
    int tbl[24] = '{12, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11,
                    12, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11};
    reset_n = 1'b0; raw = 3'b000; mode_12h = 1'b0;
    model_reset();
    repeat (3) cycle();
    reset_n = 1'b1;

    // Free run: one sec_tick every TPS edges.
    cnt = 0;
    for (int i = 0; i < 30 * TPS; i++) begin
      cycle();
      if (sec_tick) cnt++;
    end
    check_eq("free_ticks", cnt, 30);

    // Preload to 23:59 by adjusts, then ride through midnight.
    for (int it = 0; it < 400 && !(m_hour() == 23 && m_min() == 59); it++)
      if (m_min() != 59) press(1); else press(2);
    check_eq("preload_pm", pm, 1);
    day_cnt = 0; flag = 0;
    for (int i = 0; i < 100 * TPS; i++) begin
      cycle();
      if (flag) begin
        check_eq("hrs_after_day", {hrs_d, hrs_u}, 8'h00);
        flag = 0;
      end
      if (day_tick) begin
        check_eq("day_zero", {min_d, min_u, sec_d, sec_u, pm}, 0);
        check_eq("hrs_lag", {hrs_d, hrs_u}, 8'h23);
        flag = 1;
      end
    end
    check_eq("day_count", day_cnt, 1);

    // Held minute button at mm=59: one press, wraps without hour carry.
    for (int it = 0; it < 400 && !(m_min() == 59 && m_sec() < 45); it++)
      if (m_min() != 59 || m_sec() >= 45) press(1); else cycle();
    hcap = m_hour();
    raw[1] = 1'b1; repeat (10) cycle();
    raw[1] = 1'b0; repeat (10) cycle();
    check_eq("min_wrap", {min_d, min_u}, 8'h00);
    check_eq("no_carry_h", 32'(hrs_d) * 10 + 32'(hrs_u), hcap);

    // Short glitch on the seconds button.
    raw[0] = 1'b1; repeat (2) cycle();
    raw[0] = 1'b0; repeat (12) cycle();

    // Seconds press landing on the tick that takes 58 -> 59.
    for (int it = 0; it < 100 * TPS && !(m_sec() == 57 && n % TPS == 0); it++) cycle();
    target = n + 2 * TPS;
    for (int it = 0; it < 4 * TPS && n + 1 != target - DB - 3; it++) cycle();
    raw[0] = 1'b1;
    for (int i = 0; i < DB + 6; i++) begin
      cycle();
      if (n == target)     check_eq("coinc_tick", {sec_d, sec_u}, 8'h59);
      if (n == target + 1) check_eq("coinc_adj",  {sec_d, sec_u}, 8'h00);
    end
    raw[0] = 1'b0; repeat (10) cycle();

    // 12-hour display walk through all 24 hours.
    mode_12h = 1'b1;
    for (int it = 0; it < 30 && m_hour() != 0; it++) press(2);
    repeat (3) cycle();
    for (int j = 0; j < 24; j++) begin
      if (j == 12) begin
        mode_12h = 1'b0; repeat (3) cycle();
        mode_12h = 1'b1; repeat (2) cycle();
      end
      check_eq("hrs12", 32'(hrs_d) * 10 + 32'(hrs_u), tbl[j]);
      check_eq("pm12", pm, (j >= 12));
      press(2);
    end

    // Random buttons and mode flips.
    repeat (150) begin
      raw = 3'($urandom);
      if ($urandom_range(0, 7) == 0) mode_12h = ~mode_12h;
      repeat ($urandom_range(1, 12)) cycle();
    end
    raw = 3'b000; repeat (20) cycle();

    // Reset mid-second with the seconds button held.
    raw[0] = 1'b1;
    repeat (2) cycle();
    reset_n = 1'b0; #1;
    check_eq("rst_async", outs(), 0);
    cycle();
    reset_n = 1'b1;
    repeat (30) cycle();
    raw[0] = 1'b0;
    repeat (20) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
